// File: rtl/s64x7_bus16_bridge.sv
// Narrows one 64-bit CPU transfer into up to four 16-bit memory beats,
// skipping unselected half-word lanes and reassembling read data.
module s64x7_bus16_bridge #(
  parameter int MEM_AW = 24
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [63:3]       adr_i,
  input  logic              cyc_i,
  input  logic              stb_i,
  input  logic [7:0]        sel_i,
  input  logic              we_i,
  input  logic              vpa_i,
  input  logic [63:0]       dat_i,
  output logic              ack_o,
  output logic [63:0]       dat_o,
  output logic [MEM_AW:1]   mem_adr_o,
  output logic              mem_cyc_o,
  output logic              mem_stb_o,
  output logic [1:0]        mem_sel_o,
  output logic              mem_we_o,
  output logic              mem_vpa_o,
  output logic [15:0]       mem_dat_o,
  input  logic [15:0]       mem_dat_i,
  input  logic              mem_ack_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BEAT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;

  logic [MEM_AW:3]   adr_q, adr_d;
  logic [7:0]        sel_q, sel_d;
  logic              we_q, we_d;
  logic [63:0]       wdat_q, wdat_d;
  logic [63:0]       rbuf_q, rbuf_d;
  logic [1:0]        beat_q, beat_d;

  logic              ack_q, ack_d;
  logic [63:0]       dat_q, dat_d;
  logic [MEM_AW:1]   mem_adr_q, mem_adr_d;
  logic              mem_cyc_q, mem_cyc_d;
  logic              mem_stb_q, mem_stb_d;
  logic [1:0]        mem_sel_q, mem_sel_d;
  logic              mem_we_q, mem_we_d;
  logic              mem_vpa_q, mem_vpa_d;
  logic [15:0]       mem_dat_q, mem_dat_d;

  logic              req;
  logic [2:0]        first_lane;
  logic [2:0]        next_lane;
  logic [63:0]       rbuf_upd;
  logic              mem_clr;

  // Address bits above the memory window never reach the narrow bus.
  logic              unused_adr;
  assign unused_adr = ^adr_i[63:MEM_AW+1];

  // A half-word lane takes part in the transfer when either of its byte selects is set.
  function automatic logic [3:0] lanes_of(input logic [7:0] sel);
    logic [3:0] m;
    for (int i = 0; i < 4; i++) begin
      m[i] = |sel[2*i +: 2];
    end
    return m;
  endfunction

  // Returns {found, lane} for the lowest set lane in the mask.
  function automatic logic [2:0] lowest_lane(input logic [3:0] m);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) r = {1'b1, 2'(i)};
    end
    return r;
  endfunction

  function automatic logic [3:0] above_mask(input logic [1:0] b);
    return 4'b1110 << b;
  endfunction

  assign req        = cyc_i && stb_i;
  assign first_lane = lowest_lane(lanes_of(sel_i));
  assign next_lane  = lowest_lane(lanes_of(sel_q) & above_mask(beat_q));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (req) state_d = (sel_i == 8'h00) ? S_DONE : S_BEAT;
      S_BEAT: begin
        if (!cyc_i)                        state_d = S_IDLE;
        else if (mem_ack_i && !next_lane[2]) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    adr_d     = adr_q;
    sel_d     = sel_q;
    we_d      = we_q;
    wdat_d    = wdat_q;
    rbuf_d    = rbuf_q;
    beat_d    = beat_q;
    ack_d     = 1'b0;
    dat_d     = '0;
    mem_adr_d = mem_adr_q;
    mem_cyc_d = mem_cyc_q;
    mem_stb_d = mem_stb_q;
    mem_sel_d = mem_sel_q;
    mem_we_d  = mem_we_q;
    mem_vpa_d = mem_vpa_q;
    mem_dat_d = mem_dat_q;
    mem_clr   = 1'b0;
    rbuf_upd  = rbuf_q;
    rbuf_upd[{beat_q, 4'b0000} +: 16] = mem_dat_i;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          adr_d  = adr_i[MEM_AW:3];
          sel_d  = sel_i;
          we_d   = we_i;
          wdat_d = dat_i;
          rbuf_d = '0;
          beat_d = first_lane[1:0];
          if (sel_i == 8'h00) begin
            ack_d = 1'b1;
          end else begin
            mem_cyc_d = 1'b1;
            mem_stb_d = 1'b1;
            mem_adr_d = {adr_i[MEM_AW:3], first_lane[1:0]};
            mem_sel_d = sel_i[{first_lane[1:0], 1'b0} +: 2];
            mem_we_d  = we_i;
            mem_vpa_d = vpa_i;
            mem_dat_d = dat_i[{first_lane[1:0], 4'b0000} +: 16];
          end
        end
      end
      S_BEAT: begin
        if (!cyc_i) begin
          // CPU abandoned the cycle: discard partial read data, no ack.
          rbuf_d  = '0;
          mem_clr = 1'b1;
        end else if (mem_ack_i) begin
          if (!we_q) rbuf_d = rbuf_upd;
          if (next_lane[2]) begin
            beat_d    = next_lane[1:0];
            mem_adr_d = {adr_q, next_lane[1:0]};
            mem_sel_d = sel_q[{next_lane[1:0], 1'b0} +: 2];
            mem_dat_d = wdat_q[{next_lane[1:0], 4'b0000} +: 16];
          end else begin
            mem_clr = 1'b1;
            ack_d   = 1'b1;
            dat_d   = we_q ? 64'd0 : rbuf_upd;
          end
        end
      end
      default: ;
    endcase

    if (mem_clr) begin
      mem_cyc_d = 1'b0;
      mem_stb_d = 1'b0;
      mem_adr_d = '0;
      mem_sel_d = 2'b00;
      mem_we_d  = 1'b0;
      mem_vpa_d = 1'b0;
      mem_dat_d = 16'h0000;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      adr_q     <= '0;
      sel_q     <= 8'h00;
      we_q      <= 1'b0;
      wdat_q    <= 64'd0;
      rbuf_q    <= 64'd0;
      beat_q    <= 2'b00;
      ack_q     <= 1'b0;
      dat_q     <= 64'd0;
      mem_adr_q <= '0;
      mem_cyc_q <= 1'b0;
      mem_stb_q <= 1'b0;
      mem_sel_q <= 2'b00;
      mem_we_q  <= 1'b0;
      mem_vpa_q <= 1'b0;
      mem_dat_q <= 16'h0000;
    end else begin
      adr_q     <= adr_d;
      sel_q     <= sel_d;
      we_q      <= we_d;
      wdat_q    <= wdat_d;
      rbuf_q    <= rbuf_d;
      beat_q    <= beat_d;
      ack_q     <= ack_d;
      dat_q     <= dat_d;
      mem_adr_q <= mem_adr_d;
      mem_cyc_q <= mem_cyc_d;
      mem_stb_q <= mem_stb_d;
      mem_sel_q <= mem_sel_d;
      mem_we_q  <= mem_we_d;
      mem_vpa_q <= mem_vpa_d;
      mem_dat_q <= mem_dat_d;
    end
  end

  assign ack_o     = ack_q;
  assign dat_o     = dat_q;
  assign mem_adr_o = mem_adr_q;
  assign mem_cyc_o = mem_cyc_q;
  assign mem_stb_o = mem_stb_q;
  assign mem_sel_o = mem_sel_q;
  assign mem_we_o  = mem_we_q;
  assign mem_vpa_o = mem_vpa_q;
  assign mem_dat_o = mem_dat_q;

endmodule
